// File: rtl/audio_sample_streamer_if.sv
// Avalon-MM pipelined read bundle between the sample streamer (master) and flash (slave).
interface audio_sample_streamer_if #(
  parameter int ADDR_W = 23
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic              mem_waitrequest;
  logic [31:0]       mem_readdata;
  logic              mem_readdatavalid;

  modport master (
    output mem_addr, mem_read,
    input  mem_waitrequest, mem_readdata, mem_readdatavalid
  );

  modport slave (
    input  mem_addr, mem_read,
    output mem_waitrequest, mem_readdata, mem_readdatavalid
  );
endinterface

// File: rtl/audio_sample_streamer.sv
// Fetches packed 32-bit words from flash and plays them out as four signed
// 8-bit samples per word, one per sample_tick, with silence on pause/underrun.
module audio_sample_streamer #(
  parameter int                ADDR_W    = 23,
  parameter logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(23'h7FFFF)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           sample_tick,
  input  logic                           play,
  input  logic                           restart,
  audio_sample_streamer_if.master        mem,
  output logic [7:0]                     audio_out,
  output logic                           sample_strobe,
  output logic                           silent,
  output logic                           underrun
);

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_REQ  = 2'd1,
    F_WAIT = 2'd2
  } fetch_state_e;

  fetch_state_e      r_state, w_state;
  logic [ADDR_W-1:0] r_mem_addr, r_next_addr, w_next_addr;
  logic              r_mem_read, r_discard, w_discard;
  logic              w_issue, w_resp, w_fill;
  logic [31:0]       r_cur, r_nxt, w_cur, w_nxt;
  logic              r_cur_v, r_nxt_v, w_cur_v, w_nxt_v;
  logic [1:0]        r_idx, w_idx;
  logic [7:0]        r_audio, w_audio;
  logic              r_strobe, r_silent, r_underrun;
  logic              w_strobe, w_silent, w_underrun;

  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_read  = r_mem_read;
  assign audio_out     = r_audio;
  assign sample_strobe = r_strobe;
  assign silent        = r_silent;
  assign underrun      = r_underrun;

  always_comb begin
    w_state = r_state;
    w_issue = 1'b0;
    w_resp  = 1'b0;
    case (r_state)
      F_IDLE: begin
        if (!r_nxt_v) begin
          w_state = F_REQ;
          w_issue = 1'b1;
        end else begin
          w_state = F_IDLE;
        end
      end
      F_REQ: begin
        if (!mem.mem_waitrequest) begin
          w_state = F_WAIT;
        end else begin
          w_state = F_REQ;
        end
      end
      F_WAIT: begin
        if (mem.mem_readdatavalid) begin
          w_state = F_IDLE;
          w_resp  = 1'b1;
        end else begin
          w_state = F_WAIT;
        end
      end
      default: w_state = F_IDLE;
    endcase
  end

  // A restart orphans any request already on the bus; its response must be dropped.
  always_comb begin
    w_discard   = r_discard;
    w_fill      = w_resp && !r_discard && !restart;
    w_next_addr = r_next_addr;
    if (restart && ((r_state == F_REQ) || ((r_state == F_WAIT) && !mem.mem_readdatavalid))) begin
      w_discard = 1'b1;
    end else if (w_resp) begin
      w_discard = 1'b0;
    end else begin
      w_discard = r_discard;
    end
    if (restart) begin
      w_next_addr = '0;
    end else if (w_fill) begin
      w_next_addr = (r_next_addr == LAST_ADDR) ? '0 : r_next_addr + ADDR_W'(1);
    end else begin
      w_next_addr = r_next_addr;
    end
  end

  // Tick consumption sees pre-edge buffers; incoming data lands after it.
  always_comb begin
    w_cur      = r_cur;
    w_cur_v    = r_cur_v;
    w_nxt      = r_nxt;
    w_nxt_v    = r_nxt_v;
    w_idx      = r_idx;
    w_audio    = r_audio;
    w_silent   = r_silent;
    w_strobe   = 1'b0;
    w_underrun = r_underrun;
    if (restart) begin
      w_cur_v    = 1'b0;
      w_nxt_v    = 1'b0;
      w_idx      = 2'd0;
      w_underrun = 1'b0;
      if (sample_tick) begin
        w_strobe = 1'b1;
        w_audio  = 8'h00;
        w_silent = 1'b1;
      end else begin
        w_strobe = 1'b0;
      end
    end else begin
      if (sample_tick) begin
        w_strobe = 1'b1;
        if (play && r_cur_v) begin
          w_audio  = r_cur[{r_idx, 3'b000} +: 8];
          w_silent = 1'b0;
          if (r_idx == 2'd3) begin
            w_cur   = r_nxt;
            w_cur_v = r_nxt_v;
            w_nxt_v = 1'b0;
            w_idx   = 2'd0;
          end else begin
            w_idx = r_idx + 2'd1;
          end
        end else begin
          w_audio    = 8'h00;
          w_silent   = 1'b1;
          w_underrun = play ? 1'b1 : r_underrun;
        end
      end else begin
        w_strobe = 1'b0;
      end
      if (w_fill) begin
        if (!w_cur_v) begin
          w_cur   = mem.mem_readdata;
          w_cur_v = 1'b1;
        end else begin
          w_nxt   = mem.mem_readdata;
          w_nxt_v = 1'b1;
        end
      end else begin
        w_nxt_v = w_nxt_v;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= F_IDLE;
      r_mem_addr  <= '0;
      r_next_addr <= '0;
      r_mem_read  <= 1'b0;
      r_discard   <= 1'b0;
      r_cur       <= 32'h0000_0000;
      r_nxt       <= 32'h0000_0000;
      r_cur_v     <= 1'b0;
      r_nxt_v     <= 1'b0;
      r_idx       <= 2'd0;
      r_audio     <= 8'h00;
      r_strobe    <= 1'b0;
      r_silent    <= 1'b1;
      r_underrun  <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_mem_read  <= (w_state == F_REQ);
      r_next_addr <= w_next_addr;
      r_discard   <= w_discard;
      if (w_issue) begin
        r_mem_addr <= w_next_addr;
      end else begin
        r_mem_addr <= r_mem_addr;
      end
      r_cur       <= w_cur;
      r_nxt       <= w_nxt;
      r_cur_v     <= w_cur_v;
      r_nxt_v     <= w_nxt_v;
      r_idx       <= w_idx;
      r_audio     <= w_audio;
      r_strobe    <= w_strobe;
      r_silent    <= w_silent;
      r_underrun  <= w_underrun;
    end
  end

endmodule

// File: tb/tb_audio_sample_streamer.sv
// Randomized bench: Avalon slave model plus a byte-queue reference of the sample stream.
module tb_audio_sample_streamer;
  localparam int                ADDR_W = 23;
  localparam logic [ADDR_W-1:0] LAST   = 23'd3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sample_tick = 1'b0;
  logic       play = 1'b0;
  logic       restart = 1'b0;
  logic [7:0] audio_out;
  logic       sample_strobe, silent, underrun;

  audio_sample_streamer_if #(.ADDR_W(ADDR_W)) bus();

  audio_sample_streamer #(.ADDR_W(ADDR_W), .LAST_ADDR(LAST)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .sample_tick   (sample_tick),
    .play          (play),
    .restart       (restart),
    .mem           (bus),
    .audio_out     (audio_out),
    .sample_strobe (sample_strobe),
    .silent        (silent),
    .underrun      (underrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  logic [7:0]        q[$];
  logic [7:0]        e_audio;
  logic              e_silent, e_underrun;
  logic [ADDR_W-1:0] e_addr;
  bit                pend, pend_stale, req_stale;
  logic [ADDR_W-1:0] pend_addr;
  int                pend_cnt;
  bit                prev_stall;
  logic [ADDR_W-1:0] prev_addr;
  int                wr_mode;   // 0 random, 1 never stall, 2 always stall
  int                lat_max;
  bit                long3;
  logic [8:0]        obs[$];
  logic [ADDR_W-1:0] acc_addr[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] word_of(input logic [ADDR_W-1:0] a);
    logic [7:0] b;
    b = 8'(a) << 2;
    return {b + 8'd4, b + 8'd3, b + 8'd2, b + 8'd1};
  endfunction

  task automatic step(input bit tk, input bit pl, input bit rs);
    bit                pre_read, wr, rdv;
    logic [ADDR_W-1:0] pre_addr;
    logic [31:0]       w;
    int                pre_q;
    sample_tick = tk;
    play        = pl;
    restart     = rs;
    if (wr_mode == 0) wr = ($urandom_range(0, 3) == 0);
    else wr = (wr_mode == 2);
    rdv = pend && (pend_cnt == 0);
    bus.mem_waitrequest   = wr;
    bus.mem_readdatavalid = rdv;
    bus.mem_readdata      = rdv ? word_of(pend_addr) : $urandom;
    pre_read = bus.mem_read;
    pre_addr = bus.mem_addr;
    pre_q    = q.size();
    if (prev_stall) begin
      check_val("avl_read_hold", 32'(pre_read), 32'd1);
      check_val("avl_addr_hold", 32'(pre_addr), 32'(prev_addr));
    end
    prev_stall = pre_read && wr;
    prev_addr  = pre_addr;
    @(posedge clk);
    #1;
    // sample path: tick sees the queue as it was before this edge
    if (rs) begin
      q.delete();
      e_underrun = 1'b0;
      if (tk) begin e_audio = 8'h00; e_silent = 1'b1; end
    end else if (tk) begin
      if (pl && q.size() > 0) begin
        e_audio  = q.pop_front();
        e_silent = 1'b0;
      end else begin
        e_audio  = 8'h00;
        e_silent = 1'b1;
        if (pl) e_underrun = 1'b1;
      end
    end
    // memory side
    if (pend && !rdv) pend_cnt--;
    if (rdv) begin
      pend = 1'b0;
      w = word_of(pend_addr);
      if (!pend_stale && !rs)
        for (int i = 0; i < 4; i++) q.push_back(w[8*i +: 8]);
    end
    if (pre_read && !wr) begin
      check_val("one_outstanding", 32'(pend), 32'd0);
      acc_addr.push_back(pre_addr);
      if (!req_stale && !rs) begin
        check_val("fetch_addr", 32'(pre_addr), 32'(e_addr));
        e_addr = (e_addr == LAST) ? '0 : e_addr + 1'b1;
      end
      pend       = 1'b1;
      pend_addr  = pre_addr;
      pend_cnt   = (long3 && pre_addr == 3) ? 8 : $urandom_range(0, lat_max);
      pend_stale = req_stale || rs;
      req_stale  = 1'b0;
    end
    if (rs) begin
      e_addr = '0;
      if (pre_read && wr) req_stale = 1'b1;
      if (pend) pend_stale = 1'b1;
    end
    if (bus.mem_read && !pre_read) check_val("no_fetch_when_full", 32'(pre_q <= 4), 32'd1);
    check_val("strobe", 32'(sample_strobe), 32'(tk));
    check_val("audio", 32'(audio_out), 32'(e_audio));
    check_val("silent", 32'(silent), 32'(e_silent));
    check_val("underrun", 32'(underrun), 32'(e_underrun));
    if (sample_strobe) obs.push_back({silent, audio_out});
  endtask

  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    #1;
    check_val("rst_audio", 32'(audio_out), 32'h0);
    check_val("rst_strobe", 32'(sample_strobe), 32'h0);
    check_val("rst_silent", 32'(silent), 32'h1);
    check_val("rst_underrun", 32'(underrun), 32'h0);
    check_val("rst_mem_read", 32'(bus.mem_read), 32'h0);
    check_val("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    q.delete();
    obs.delete();
    acc_addr.delete();
    e_audio = 8'h00; e_silent = 1'b1; e_underrun = 1'b0; e_addr = '0;
    pend = 1'b0; pend_stale = 1'b0; req_stale = 1'b0; prev_stall = 1'b0;
    reset_n = 1'b1;
    step(1'b0, 1'b1, 1'b0);
    check_val("first_req", 32'(bus.mem_read), 32'h1);
  endtask

  initial begin
    bit found;
    int k;
    logic pl;
    bus.mem_waitrequest = 1'b0;
    bus.mem_readdatavalid = 1'b0;
    bus.mem_readdata = 32'h0;
    wr_mode = 1; lat_max = 0; long3 = 1'b0;
    #10;
    do_reset();

    // startup, byte order and wrap with a zero-wait memory
    for (int c = 0; c < 160; c++) step((c % 8) == 7, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) check_val("byte_order", 32'(obs[i]), 32'((i % 16) + 1));
    for (int i = 0; i < 5; i++) check_val("addr_seq", 32'(acc_addr[i]), 32'((i == 4) ? 0 : i));

    // underrun: memory stalls for 100 cycles
    do_reset();
    wr_mode = 2;
    for (int c = 0; c < 100; c++) step((c % 8) == 7, 1'b1, 1'b0);
    check_val("underrun_silent", 32'(obs[0]), 32'h100);
    check_val("underrun_sticky", 32'(underrun), 32'h1);
    wr_mode = 1;
    for (int c = 100; c < 160; c++) step((c % 8) == 7, 1'b1, 1'b0);
    found = 1'b0;
    foreach (obs[i]) if (!found && !obs[i][8]) begin
      found = 1'b1;
      check_val("first_real_byte", 32'(obs[i]), 32'h001);
    end
    check_val("real_byte_seen", 32'(found), 32'h1);

    // pause for ticks 2..4
    do_reset();
    wr_mode = 0; lat_max = 3;
    for (int c = 0; c < 24; c++) step(1'b0, 1'b1, 1'b0);
    obs.delete();
    for (int t = 0; t < 12; t++) begin
      pl = !(t >= 2 && t <= 4);
      for (int c = 0; c < 8; c++) step(c == 7, pl, 1'b0);
    end
    check_val("pause_s0", 32'(obs[0]), 32'h001);
    check_val("pause_s1", 32'(obs[1]), 32'h002);
    for (int i = 2; i < 5; i++) check_val("pause_silent", 32'(obs[i]), 32'h100);
    check_val("pause_resume", 32'(obs[5]), 32'h003);

    // restart while the read of the last word is outstanding
    do_reset();
    wr_mode = 1; lat_max = 0; long3 = 1'b1;
    found = 1'b0;
    k = 0;
    while (!found && k < 300) begin
      step((k % 4) == 3, 1'b1, 1'b0);
      found = pend && (pend_addr == 3) && (pend_cnt > 2);
      k++;
    end
    check_val("addr3_outstanding", 32'(found), 32'h1);
    acc_addr.delete();
    obs.delete();
    step(1'b1, 1'b1, 1'b1);
    check_val("restart_strobe", 32'({silent, audio_out}), 32'h100);
    for (int c = 0; c < 20; c++) step(1'b0, 1'b1, 1'b0);
    check_val("restart_underrun", 32'(underrun), 32'h0);
    check_val("restart_fetch_seen", 32'(acc_addr.size() > 0), 32'h1);
    if (acc_addr.size() > 0) check_val("restart_addr0", 32'(acc_addr[0]), 32'h0);
    for (int c = 0; c < 16; c++) step((c % 8) == 7, 1'b1, 1'b0);
    check_val("restart_sample", 32'(obs[1]), 32'h001);
    long3 = 1'b0;

    // randomized traffic with stalls, variable latency, pauses and restarts
    do_reset();
    wr_mode = 0; lat_max = 3;
    for (int c = 0; c < 3000; c++)
      step($urandom_range(0, 4) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 59) == 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/audio_sample_streamer.md
# audio_sample_streamer

Producer end of the audio sample path. It fetches packed 32-bit audio words from flash over an Avalon-MM read master with pipelined reads, and unpacks each word into four signed 8-bit samples. On each audio-rate tick it presents one sample with a one-cycle strobe and a silent qualifier. `audio_out`, `sample_strobe` and `silent` drive the audio averaging block's `input_audio`, `start_averaging_flag` and `silent_flag` inputs directly, and `audio_out` also drives the audio DAC path.

## Interface
Parameters:
- `ADDR_W`, default 23: flash word-address width.
- `LAST_ADDR`, default 23'h7FFFF: last word address of the clip. The fetch address wraps to 0 after this word.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `sample_tick`  in  1  one-cycle pulse at the audio sample rate.
- `play`  in  1  level. 1 = play, 0 = pause.
- `restart`  in  1  one-cycle pulse. Flushes the buffers and resumes fetching from address 0.
- `mem_addr`  out  ADDR_W  flash word address.
- `mem_read`  out  1  Avalon read request.
- `mem_waitrequest`  in  1  Avalon stall.
- `mem_readdata`  in  32  read data.
- `mem_readdatavalid`  in  1  read data valid.
- `audio_out`  out  8  current sample, two's complement.
- `sample_strobe`  out  1  one-cycle pulse each time `audio_out` is (re)issued.
- `silent`  out  1  qualifies the current strobe as a non-audio sample.
- `underrun`  out  1  sticky. Set on any underrun; cleared by `restart` or reset.

## Operation
- Buffering:
  - Current word register `cur` with valid bit and 2-bit byte index `idx`.
  - One prefetch register `nxt` with valid bit.
  - Byte order: `idx` 0 → `readdata[7:0]` first, `idx` 3 → `[31:24]` last.
- Fetch FSM states:
  - `F_IDLE`: go to `F_REQ` when `nxt` is not valid and no read is outstanding.
  - `F_REQ`: assert `mem_read` with `mem_addr` held stable. Go to `F_WAIT` in the cycle `mem_waitrequest` = 0.
  - `F_WAIT`: wait for `mem_readdatavalid`. Write the data into `cur` if `cur` is empty, otherwise into `nxt`. Advance the address (`LAST_ADDR` → 0) and return to `F_IDLE`.
- At most one read is outstanding at any time.
- Output on a `sample_tick` while `play` = 1:
  - `cur` valid: `audio_out` ← `cur` byte `idx`, `silent` ← 0, `sample_strobe` pulses.
  - If `idx` = 3, `cur` ← `nxt` (invalid if `nxt` was empty), `nxt` is cleared and `idx` ← 0. Otherwise `idx` + 1.
  - `cur` empty (underrun): `audio_out` ← 8'h00, `silent` ← 1, `sample_strobe` pulses, `underrun` ← 1.
- Output on a `sample_tick` while `play` = 0:
  - `sample_strobe` pulses with `silent` ← 1 and `audio_out` ← 8'h00.
  - Buffers and `idx` are untouched; fetching continues until both words are full.
- Restart:
  - Clears the `cur`/`nxt` valid bits and sets `idx` ← 0, next address ← 0, `underrun` ← 0.
  - A request stalled in `F_REQ` stays asserted with its old address until accepted.
  - The response to any request accepted before the restart is discarded via a discard flag; the next fetch is from address 0.
- Simultaneous events:
  - `restart` with `sample_tick` in the same cycle: restart wins. The strobe is issued with `silent` = 1 and `audio_out` = 0, and `underrun` is not set.
  - `sample_tick` with `mem_readdatavalid` filling an empty `cur`: the tick sees the pre-edge state, so it counts as an underrun. The data lands in `cur`.
  - `sample_tick` consuming byte 3 with `readdatavalid` in the same cycle: the data goes to the newly vacated `cur` if `nxt` was empty, otherwise to `nxt`. No data is lost.

## Timing
- Reset values: `mem_addr` 0, `mem_read` 0, `audio_out` 8'h00, `sample_strobe` 0, `silent` 1, `underrun` 0. FSM in `F_IDLE`, all buffers invalid.
- First fetch request: `mem_read` rises on the first clock after `reset_n` deasserts.
- Output latency: `audio_out`, `silent` and `sample_strobe` are registered and update 1 cycle after `sample_tick`.
- Output hold: `sample_strobe` is high for exactly 1 cycle per tick. `audio_out` and `silent` hold until the next strobe.
- Avalon rules: `mem_addr` and `mem_read` are stable while `mem_waitrequest` = 1. `mem_read` drops in the cycle after acceptance.
- Data to first sample: `mem_readdatavalid` is visible on the first tick at least 1 cycle later.

## Test plan
- Startup and byte order:
  - Stimulus: reset, zero-wait memory returning `mem_readdata` = 32'h04_03_02_01 at addr 0 and 32'h08_07_06_05 at addr 1, `play` = 1, ticks every 8 cycles.
  - Required response: strobes carry 01,02,03,04,05,06,… with `silent` = 0. `mem_addr` sequence 0,1,2.
- Wrap:
  - Stimulus: `LAST_ADDR` = 3, play 16+ samples.
  - Required response: reads of 0,1,2,3 followed by 0. Samples repeat with period 16.
- Underrun:
  - Stimulus: `mem_waitrequest` held at 1 for 100 cycles after reset, ticks every 8 cycles.
  - Required response: strobes carry 00 with `silent` = 1 and `underrun` = 1. The first real byte appears on the first tick after data arrives.
- Pause:
  - Stimulus: drop `play` after sample 2 for 3 ticks, then raise it.
  - Required response: 3 strobes carrying 00 with `silent` = 1, then sample 3 resumes. No read is issued while both buffers are full.
- Restart mid-read:
  - Stimulus: pulse `restart` while `F_WAIT` holds an outstanding read of addr 5.
  - Required response: the addr-5 response is discarded, the next `mem_addr` is 0, the next audio sample is byte 0 of word 0, and `underrun` reads 0.
- Asynchronous reset:
  - Stimulus: assert `reset_n` low mid-stream, between clock edges.
  - Required response: all outputs take their reset values immediately, without waiting for a clock edge.
